// File: rtl/dice_roll_sequencer.sv
// Single-die roll controller: latches the die size on press, spins a BCD value while held,
// tumbles on the 32 Hz tick after release, then shows the result for a timed period.
module dice_roll_sequencer #(
    parameter int unsigned TUMBLE_STEPS = 8,
    parameter int unsigned SHOW_TICKS   = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic [6:0] btn,
    output logic [3:0] digit10,
    output logic [3:0] digit1,
    output logic       show,
    output logic       digit10_en,
    output logic       rolling,
    output logic       done
);
    localparam logic [2:0] DIE_D100 = 3'd6;

    typedef enum logic [1:0] {ST_IDLE, ST_HELD, ST_TUMBLE, ST_SHOW} state_t;

    state_t     state_q, state_d;
    logic [2:0] die_q, die_d;
    logic [3:0] tens_q, tens_d;
    logic [3:0] ones_q, ones_d;
    logic [7:0] step_q, step_d;
    logic [7:0] timer_q, timer_d;
    logic       done_q, done_d;

    logic       press;
    logic [2:0] sel;
    logic [3:0] dec_tens, dec_ones;

    function automatic logic [7:0] size_bcd(input logic [2:0] idx);
        case (idx)
            3'd0:    size_bcd = 8'h04;
            3'd1:    size_bcd = 8'h06;
            3'd2:    size_bcd = 8'h08;
            3'd3:    size_bcd = 8'h10;
            3'd4:    size_bcd = 8'h12;
            3'd5:    size_bcd = 8'h20;
            3'd6:    size_bcd = 8'h00;
            default: size_bcd = 8'h04;
        endcase
    endfunction

    assign press = |btn;

    // Scan from the top so the lowest active index is the last one written.
    always_comb begin
        sel = '0;
        for (int unsigned i = 7; i > 0; i--) begin
            if (btn[i-1]) sel = 3'(i - 1);
        end
    end

    // BCD 00 stands for 100, so 00 - 1 naturally borrows to 99.
    always_comb begin
        dec_tens = tens_q;
        dec_ones = ones_q;
        if ({tens_q, ones_q} == 8'h01) begin
            {dec_tens, dec_ones} = size_bcd(die_q);
        end else if (ones_q == 4'd0) begin
            dec_ones = 4'd9;
            dec_tens = (tens_q == 4'd0) ? 4'd9 : tens_q - 4'd1;
        end else begin
            dec_ones = ones_q - 4'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        die_d   = die_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        step_d  = step_q;
        timer_d = timer_q;
        done_d  = 1'b0;
        if ((state_q != ST_HELD) && press) begin
            state_d          = ST_HELD;
            die_d            = sel;
            {tens_d, ones_d} = size_bcd(sel);
        end else begin
            unique case (state_q)
                ST_IDLE: ;
                ST_HELD: begin
                    if (press) begin
                        tens_d = dec_tens;
                        ones_d = dec_ones;
                    end else begin
                        step_d  = 8'(TUMBLE_STEPS);
                        state_d = ST_TUMBLE;
                    end
                end
                ST_TUMBLE: begin
                    if (tick) begin
                        tens_d = dec_tens;
                        ones_d = dec_ones;
                        step_d = step_q - 8'd1;
                        if (step_q == 8'd1) begin
                            state_d = ST_SHOW;
                            done_d  = 1'b1;
                            timer_d = 8'(SHOW_TICKS);
                        end
                    end
                end
                ST_SHOW: begin
                    if (tick) begin
                        timer_d = timer_q - 8'd1;
                        if (timer_q == 8'd1) state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            die_q   <= '0;
            tens_q  <= 4'd0;
            ones_q  <= 4'd1;
            step_q  <= '0;
            timer_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            die_q   <= die_d;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
            step_q  <= step_d;
            timer_q <= timer_d;
            done_q  <= done_d;
        end
    end

    assign digit10    = tens_q;
    assign digit1     = ones_q;
    assign show       = (state_q == ST_TUMBLE) || (state_q == ST_SHOW);
    assign rolling    = (state_q == ST_HELD) || (state_q == ST_TUMBLE);
    assign digit10_en = show && ((tens_q != 4'd0) ||
                                 ((die_q == DIE_D100) && ({tens_q, ones_q} == 8'h00)));
    assign done       = done_q;

endmodule

// File: tb/tb_dice_roll_sequencer.sv
// Bench for dice_roll_sequencer: integer-valued roll model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_dice_roll_sequencer;
    localparam int TS = 8;
    localparam int ST = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    logic [6:0] btn = '0;
    logic [3:0] digit10, digit1;
    logic       show, digit10_en, rolling, done;

    dice_roll_sequencer #(.TUMBLE_STEPS(TS), .SHOW_TICKS(ST)) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .btn(btn),
        .digit10(digit10), .digit1(digit1), .show(show),
        .digit10_en(digit10_en), .rolling(rolling), .done(done)
    );

    always #5 clk = ~clk;

    typedef enum {M_IDLE, M_HELD, M_TUMBLE, M_SHOW} mode_t;
    int    sizes [7] = '{4, 6, 8, 10, 12, 20, 100};
    mode_t m_mode = M_IDLE;
    int    m_n = 4, m_val = 1, m_steps = 0, m_timer = 0;
    bit    m_done = 0, m_valid = 0;

    int n_chk = 0, n_fail = 0, done_cnt = 0;

    function automatic int lowest_size(input logic [6:0] b);
        for (int i = 0; i < 7; i++) if (b[i]) return sizes[i];
        return 4;
    endfunction

    function automatic int dec_val(input int v, input int n);
        return (v == 1) ? n : v - 1;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_mode = M_IDLE; m_n = 4; m_val = 1; m_done = 0; m_valid = 1;
        end else begin
            m_done = 0;
            if (btn != 0 && m_mode != M_HELD) begin
                m_n = lowest_size(btn); m_val = m_n; m_mode = M_HELD;
            end else if (m_mode == M_HELD) begin
                if (btn != 0) m_val = dec_val(m_val, m_n);
                else begin m_steps = TS; m_mode = M_TUMBLE; end
            end else if (m_mode == M_TUMBLE && tick) begin
                m_val = dec_val(m_val, m_n);
                m_steps--;
                if (m_steps == 0) begin m_mode = M_SHOW; m_done = 1; m_timer = ST; end
            end else if (m_mode == M_SHOW && tick) begin
                m_timer--;
                if (m_timer == 0) m_mode = M_IDLE;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: dut=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [6:0] b, input logic t);
        bit e_show;
        btn = b; tick = t;
        @(negedge clk);
        if (done === 1'b1) done_cnt++;
        if (m_valid) begin
            e_show = (m_mode == M_TUMBLE) || (m_mode == M_SHOW);
            chk("model digit10", int'(digit10), (m_val % 100) / 10);
            chk("model digit1", int'(digit1), m_val % 10);
            chk("model show", int'(show), int'(e_show));
            chk("model digit10_en", int'(digit10_en),
                int'(e_show && (((m_val % 100) / 10 != 0) || m_val == 100)));
            chk("model rolling", int'(rolling),
                int'((m_mode == M_HELD) || (m_mode == M_TUMBLE)));
            chk("model done", int'(done), int'(m_done));
        end
    endtask

    task automatic ticks(input int k);
        repeat (k) begin drive('0, 1'b1); drive('0, 1'b0); end
    endtask

    initial begin
        // Reset, then idle ticks must not disturb anything.
        drive('0, 1'b0);
        drive('0, 1'b1);
        rst_n = 1'b1;
        drive('0, 1'b0);
        chk("reset digit10", int'(digit10), 0);
        chk("reset digit1", int'(digit1), 1);
        chk("reset show", int'(show), 0);
        chk("reset digit10_en", int'(digit10_en), 0);
        chk("reset done", int'(done), 0);
        ticks(3);
        chk("idle ticks digit1", int'(digit1), 1);
        chk("idle ticks show", int'(show), 0);

        // d6 held 10 cycles: 6 then nine decrements -> 3.
        done_cnt = 0;
        repeat (10) drive(7'b0000010, 1'b0);
        drive('0, 1'b0);
        chk("d6 tumble entry digit1", int'(digit1), 3);
        chk("d6 tumble entry rolling", int'(rolling), 1);
        chk("d6 tumble entry show", int'(show), 1);
        ticks(TS);
        drive('0, 1'b0);
        chk("d6 result digit1", int'(digit1), 1);
        chk("d6 result digit10", int'(digit10), 0);
        chk("d6 done count", done_cnt, 1);
        chk("d6 result show", int'(show), 1);
        chk("d6 result digit10_en", int'(digit10_en), 0);

        // d100 tapped: 100 then eight ticks -> 92.
        drive(7'b1000000, 1'b0);
        drive('0, 1'b0);
        chk("d100 load digit10", int'(digit10), 0);
        chk("d100 load digit1", int'(digit1), 0);
        chk("d100 load digit10_en", int'(digit10_en), 1);
        ticks(TS);
        chk("d100 result digit10", int'(digit10), 9);
        chk("d100 result digit1", int'(digit1), 2);
        chk("d100 result digit10_en", int'(digit10_en), 1);
        // 92 decrements while held -> 8; eight ticks wrap it to 100.
        repeat (93) drive(7'b1000000, 1'b0);
        drive('0, 1'b0);
        chk("d100 held digit1", int'(digit1), 8);
        ticks(TS);
        chk("d100 wrap digit10", int'(digit10), 0);
        chk("d100 wrap digit1", int'(digit1), 0);
        chk("d100 wrap digit10_en", int'(digit10_en), 1);
        chk("d100 wrap show", int'(show), 1);

        // d6+d20 pressed together latches d6; later button changes are ignored.
        drive(7'b0100010, 1'b0);
        chk("multi press digit1", int'(digit1), 6);
        repeat (20) begin
            drive(7'b0100000, 1'b0);
            chk("locked n tens", int'(digit10), 0);
            n_chk++;
            if (digit1 > 4'd6 || digit1 == 4'd0) begin
                n_fail++;
                $display("FAIL locked n range: dut=%0d expected=1..6", digit1);
            end
        end
        drive('0, 1'b0);
        chk("locked n tumble digit1", int'(digit1), 4);

        // Tumble 4 -> 2, then three show ticks return to IDLE with digits kept.
        done_cnt = 0;
        ticks(TS);
        chk("show entry digit1", int'(digit1), 2);
        chk("show entry done count", done_cnt, 1);
        ticks(2);
        chk("show after 2 ticks", int'(show), 1);
        drive('0, 1'b1);
        chk("show after 3 ticks", int'(show), 0);
        chk("idle rolling", int'(rolling), 0);
        chk("idle kept digit1", int'(digit1), 2);
        chk("idle kept digit10", int'(digit10), 0);

        // New press on the same cycle as a tumble tick wins.
        drive(7'b0000010, 1'b0);
        drive('0, 1'b0);
        done_cnt = 0;
        ticks(3);
        chk("pre-press digit1", int'(digit1), 3);
        drive(7'b0000001, 1'b1);
        chk("press beats tick digit1", int'(digit1), 4);
        chk("press beats tick rolling", int'(rolling), 1);
        chk("press beats tick show", int'(show), 0);
        chk("press beats tick done count", done_cnt, 0);
        drive('0, 1'b0);

        // Reset mid-tumble (with btn and tick active) abandons the roll.
        drive(7'b0000100, 1'b0);
        drive('0, 1'b0);
        ticks(3);
        chk("pre-reset digit1", int'(digit1), 5);
        done_cnt = 0;
        rst_n = 1'b0;
        drive(7'b0000001, 1'b1);
        rst_n = 1'b1;
        chk("mid reset digit1", int'(digit1), 1);
        chk("mid reset digit10", int'(digit10), 0);
        chk("mid reset show", int'(show), 0);
        chk("mid reset rolling", int'(rolling), 0);
        drive('0, 1'b1);
        chk("mid reset done count", done_cnt, 0);

        // d10 held 5 cycles: 10 then four decrements -> 6; eight ticks -> 8.
        repeat (5) drive(7'b0001000, 1'b0);
        drive('0, 1'b0);
        chk("d10 tumble entry digit1", int'(digit1), 6);
        ticks(TS);
        chk("d10 result digit1", int'(digit1), 8);
        chk("d10 result digit10", int'(digit10), 0);
        chk("d10 done count", done_cnt, 1);
        chk("d10 result digit10_en", int'(digit10_en), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
